hazard3_ahbl_arbiter_nport: RTL and testbench

HAZARD3_AHBL_ARBITER_NPORT -- requirements
Module: hazard3_ahbl_arbiter_nport

---
 rtl/hazard3_ahbl_arbiter_nport_if.sv | 51 +++++
 rtl/hazard3_ahbl_arbiter_nport.sv | 161 ++++++++++++++++
 tb/tb_hazard3_ahbl_arbiter_nport.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard3_ahbl_arbiter_nport_if.sv
// Bus bundle for the N-port AHB-Lite arbiter: upstream requester ports plus the
// downstream AHB-Lite master port. The "master" modport is the arbiter's view.
interface hazard3_ahbl_arbiter_nport_if #(
    parameter int N_PORTS = 3,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
);
    logic [N_PORTS-1:0]        up_aph_req;
    logic [N_PORTS*W_ADDR-1:0] up_haddr;
    logic [N_PORTS-1:0]        up_hwrite;
    logic [3*N_PORTS-1:0]      up_hsize;
    logic [4*N_PORTS-1:0]      up_hprot;
    logic [N_PORTS-1:0]        up_hexcl;
    logic [N_PORTS*W_DATA-1:0] up_wdata;
    logic [N_PORTS-1:0]        up_aph_ready;
    logic [N_PORTS-1:0]        up_dph_ready;
    logic [N_PORTS-1:0]        up_dph_err;
    logic [N_PORTS-1:0]        up_dph_exokay;
    logic [W_DATA-1:0]         up_rdata;
    logic [N_PORTS-1:0]        up_boosted;

    logic [W_ADDR-1:0]         ahblm_haddr;
    logic                      ahblm_hwrite;
    logic [1:0]                ahblm_htrans;
    logic [2:0]                ahblm_hsize;
    logic [2:0]                ahblm_hburst;
    logic [3:0]                ahblm_hprot;
    logic                      ahblm_hmastlock;
    logic                      ahblm_hexcl;
    logic [W_DATA-1:0]         ahblm_hwdata;
    logic                      ahblm_hready;
    logic                      ahblm_hresp;
    logic                      ahblm_hexokay;
    logic [W_DATA-1:0]         ahblm_hrdata;

    modport master (
        input  up_aph_req, up_haddr, up_hwrite, up_hsize, up_hprot, up_hexcl, up_wdata,
        output up_aph_ready, up_dph_ready, up_dph_err, up_dph_exokay, up_rdata, up_boosted,
        output ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize, ahblm_hburst,
               ahblm_hprot, ahblm_hmastlock, ahblm_hexcl, ahblm_hwdata,
        input  ahblm_hready, ahblm_hresp, ahblm_hexokay, ahblm_hrdata
    );

    modport slave (
        output up_aph_req, up_haddr, up_hwrite, up_hsize, up_hprot, up_hexcl, up_wdata,
        input  up_aph_ready, up_dph_ready, up_dph_err, up_dph_exokay, up_rdata, up_boosted,
        input  ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize, ahblm_hburst,
               ahblm_hprot, ahblm_hmastlock, ahblm_hexcl, ahblm_hwdata,
        output ahblm_hready, ahblm_hresp, ahblm_hexokay, ahblm_hrdata
    );
endinterface

// File: rtl/hazard3_ahbl_arbiter_nport.sv
// N-port AHB-Lite arbiter: fixed-priority or round-robin grant with starvation
// boosting, address-phase hold during wait states, and data-phase response routing.
module hazard3_ahbl_arbiter_nport #(
    parameter int N_PORTS      = 3,
    parameter int W_ADDR       = 32,
    parameter int W_DATA       = 32,
    parameter int ROUND_ROBIN  = 0,
    parameter int STARVE_LIMIT = 15
) (
    input logic clk,
    input logic rst_n,
    hazard3_ahbl_arbiter_nport_if.master bus
);
    localparam int         W_IDX       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [7:0] LIMIT       = 8'(STARVE_LIMIT);
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;

    logic [N_PORTS-1:0] req;
    logic [N_PORTS-1:0] grant;
    logic [N_PORTS-1:0] grant_prev_reg;
    logic [N_PORTS-1:0] owner_reg;
    logic [N_PORTS-1:0] boosted;
    logic [N_PORTS-1:0] boost_req;
    logic [N_PORTS-1:0] rr_grant;
    logic [W_IDX-1:0]   rr_ptr_reg;
    logic [W_IDX-1:0]   rr_idx;
    logic [W_IDX-1:0]   grant_idx;
    logic               rr_found;
    logic               hold_reg;
    int                 rr_sum;

    assign req       = bus.up_aph_req;
    assign boost_req = boosted & req;

    function automatic logic [N_PORTS-1:0] lowest_set(input logic [N_PORTS-1:0] v);
        logic [N_PORTS-1:0] r;
        logic               found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!found && v[i]) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Round-robin search starts just above the last granted port and wraps.
    always_comb begin
        rr_grant = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_sum   = 0;
        for (int i = 1; i <= N_PORTS; i++) begin
            rr_sum = int'(rr_ptr_reg) + i;
            if (rr_sum >= N_PORTS) begin
                rr_sum = rr_sum - N_PORTS;
            end
            rr_idx = W_IDX'(rr_sum);
            if (!rr_found && req[rr_idx]) begin
                rr_grant[rr_idx] = 1'b1;
                rr_found         = 1'b1;
            end
        end
    end

    // Grant is suppressed in reset so the bus goes idle the moment rst_n falls.
    always_comb begin
        grant = '0;
        if (!rst_n) begin
            grant = '0;
        end else if (hold_reg) begin
            grant = grant_prev_reg;
        end else if (|boost_req) begin
            grant = lowest_set(boost_req);
        end else if (ROUND_ROBIN != 0) begin
            grant = rr_grant;
        end else begin
            grant = lowest_set(req);
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant[i]) begin
                grant_idx = W_IDX'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg       <= 1'b0;
            grant_prev_reg <= '0;
            owner_reg      <= '0;
            rr_ptr_reg     <= W_IDX'(N_PORTS - 1);
        end else begin
            // An error response must not pin the address phase in place.
            hold_reg       <= (bus.ahblm_htrans == HTRANS_NSEQ) && !bus.ahblm_hready && !bus.ahblm_hresp;
            grant_prev_reg <= grant;
            if (bus.ahblm_hready) begin
                owner_reg <= grant;
            end
            if ((|grant) && bus.ahblm_hready) begin
                rr_ptr_reg <= grant_idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_starve
            logic [7:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (!req[gi] || bus.up_aph_ready[gi]) begin
                    cnt_reg <= '0;
                end else if (cnt_reg != LIMIT) begin
                    cnt_reg <= cnt_reg + 8'd1;
                end
            end
            assign boosted[gi] = (STARVE_LIMIT != 0) && (cnt_reg == LIMIT);
        end
    endgenerate

    // Grant and owner are one-hot-or-zero, so OR-ing masked slices forms the mux.
    always_comb begin
        bus.ahblm_haddr  = '0;
        bus.ahblm_hwrite = 1'b0;
        bus.ahblm_hsize  = '0;
        bus.ahblm_hprot  = '0;
        bus.ahblm_hexcl  = 1'b0;
        bus.ahblm_hwdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant[i]) begin
                bus.ahblm_haddr  = bus.ahblm_haddr | bus.up_haddr[i*W_ADDR +: W_ADDR];
                bus.ahblm_hwrite = bus.ahblm_hwrite | bus.up_hwrite[i];
                bus.ahblm_hsize  = bus.ahblm_hsize | bus.up_hsize[i*3 +: 3];
                bus.ahblm_hprot  = bus.ahblm_hprot | bus.up_hprot[i*4 +: 4];
                bus.ahblm_hexcl  = bus.ahblm_hexcl | bus.up_hexcl[i];
            end
            if (owner_reg[i]) begin
                bus.ahblm_hwdata = bus.ahblm_hwdata | bus.up_wdata[i*W_DATA +: W_DATA];
            end
        end
    end

    assign bus.ahblm_htrans    = (|grant) ? HTRANS_NSEQ : HTRANS_IDLE;
    assign bus.ahblm_hburst    = 3'b000;
    assign bus.ahblm_hmastlock = 1'b0;

    assign bus.up_aph_ready  = grant & {N_PORTS{bus.ahblm_hready}};
    assign bus.up_dph_ready  = owner_reg & {N_PORTS{bus.ahblm_hready}};
    assign bus.up_dph_err    = owner_reg & {N_PORTS{bus.ahblm_hresp}};
    assign bus.up_dph_exokay = owner_reg & {N_PORTS{bus.ahblm_hexokay}};
    assign bus.up_rdata      = bus.ahblm_hrdata;
    assign bus.up_boosted    = boosted;
endmodule

// File: tb/tb_hazard3_ahbl_arbiter_nport.sv
// Scoreboard bench: stimulus pushes expected address/data-phase events, monitors
// on the falling edge pop and compare them for a fixed-priority and a round-robin DUT.
module tb_hazard3_ahbl_arbiter_nport;
    localparam int N = 3;

    typedef struct packed {
        logic [2:0]  port_vec;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic        write;
        logic        excl;
    } aph_t;

    typedef struct packed {
        logic [2:0]  ready;
        logic [2:0]  err;
        logic [2:0]  exokay;
        logic [31:0] wdata;
    } dph_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n_fp, rst_n_rr;
    logic [2:0]    req_fp, req_rr, write_v, excl_v;
    logic          hready_fp, hresp_fp, hexokay_fp, hready_rr;
    logic [95:0]   haddr_vec, wdata_vec;
    logic [8:0]    size_vec;
    logic [11:0]   prot_vec;
    logic [31:0]   hrdata;

    int n_vec = 0;
    int n_bad = 0;

    aph_t aph_q_fp[$];
    aph_t aph_q_rr[$];
    dph_t dph_q_fp[$];
    dph_t dph_q_rr[$];

    hazard3_ahbl_arbiter_nport_if #(.N_PORTS(N), .W_ADDR(32), .W_DATA(32)) bus_fp ();
    hazard3_ahbl_arbiter_nport_if #(.N_PORTS(N), .W_ADDR(32), .W_DATA(32)) bus_rr ();

    hazard3_ahbl_arbiter_nport #(.N_PORTS(N), .W_ADDR(32), .W_DATA(32),
        .ROUND_ROBIN(0), .STARVE_LIMIT(15)) dut_fp (.clk(clk), .rst_n(rst_n_fp), .bus(bus_fp));
    hazard3_ahbl_arbiter_nport #(.N_PORTS(N), .W_ADDR(32), .W_DATA(32),
        .ROUND_ROBIN(1), .STARVE_LIMIT(15)) dut_rr (.clk(clk), .rst_n(rst_n_rr), .bus(bus_rr));

    assign bus_fp.up_aph_req    = req_fp;
    assign bus_fp.up_haddr      = haddr_vec;
    assign bus_fp.up_hwrite     = write_v;
    assign bus_fp.up_hsize      = size_vec;
    assign bus_fp.up_hprot      = prot_vec;
    assign bus_fp.up_hexcl      = excl_v;
    assign bus_fp.up_wdata      = wdata_vec;
    assign bus_fp.ahblm_hready  = hready_fp;
    assign bus_fp.ahblm_hresp   = hresp_fp;
    assign bus_fp.ahblm_hexokay = hexokay_fp;
    assign bus_fp.ahblm_hrdata  = hrdata;

    assign bus_rr.up_aph_req    = req_rr;
    assign bus_rr.up_haddr      = haddr_vec;
    assign bus_rr.up_hwrite     = write_v;
    assign bus_rr.up_hsize      = size_vec;
    assign bus_rr.up_hprot      = prot_vec;
    assign bus_rr.up_hexcl      = excl_v;
    assign bus_rr.up_wdata      = wdata_vec;
    assign bus_rr.ahblm_hready  = hready_rr;
    assign bus_rr.ahblm_hresp   = 1'b0;
    assign bus_rr.ahblm_hexokay = 1'b0;
    assign bus_rr.ahblm_hrdata  = hrdata;

    // Port k: address 0x1000*(k+1), hsize k, hprot k+8, wdata 0xCAFE0000+k.
    function automatic aph_t mk_aph(input int port, input logic wr, input logic ex);
        aph_t a;
        a.port_vec = 3'(1 << port);
        a.addr     = 32'h1000 * 32'(port + 1);
        a.size     = 3'(port);
        a.prot     = 4'(port + 8);
        a.write    = wr;
        a.excl     = ex;
        return a;
    endfunction

    function automatic dph_t mk_dph(input int port, input logic rdy, input logic er, input logic exo);
        dph_t d;
        logic [2:0] v;
        v        = 3'(1 << port);
        d.ready  = rdy ? v : 3'b000;
        d.err    = er  ? v : 3'b000;
        d.exokay = exo ? v : 3'b000;
        d.wdata  = 32'hCAFE0000 + 32'(port);
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon_fp
        aph_t ga;
        dph_t gd;
        if (bus_fp.up_aph_ready != 3'b000) begin
            ga = {bus_fp.up_aph_ready, bus_fp.ahblm_haddr, bus_fp.ahblm_hsize,
                  bus_fp.ahblm_hprot, bus_fp.ahblm_hwrite, bus_fp.ahblm_hexcl};
            if (aph_q_fp.size() == 0) chk("fp_aph_unexpected", 64'(ga), 64'(0));
            else chk("fp_aph", 64'(ga), 64'(aph_q_fp.pop_front()));
        end
        if ((bus_fp.up_dph_ready | bus_fp.up_dph_err | bus_fp.up_dph_exokay) != 3'b000) begin
            gd = {bus_fp.up_dph_ready, bus_fp.up_dph_err, bus_fp.up_dph_exokay, bus_fp.ahblm_hwdata};
            if (dph_q_fp.size() == 0) chk("fp_dph_unexpected", 64'(gd), 64'(0));
            else chk("fp_dph", 64'(gd), 64'(dph_q_fp.pop_front()));
        end
    end

    always @(negedge clk) begin : mon_rr
        aph_t ga;
        dph_t gd;
        if (bus_rr.up_aph_ready != 3'b000) begin
            ga = {bus_rr.up_aph_ready, bus_rr.ahblm_haddr, bus_rr.ahblm_hsize,
                  bus_rr.ahblm_hprot, bus_rr.ahblm_hwrite, bus_rr.ahblm_hexcl};
            if (aph_q_rr.size() == 0) chk("rr_aph_unexpected", 64'(ga), 64'(0));
            else chk("rr_aph", 64'(ga), 64'(aph_q_rr.pop_front()));
        end
        if ((bus_rr.up_dph_ready | bus_rr.up_dph_err | bus_rr.up_dph_exokay) != 3'b000) begin
            gd = {bus_rr.up_dph_ready, bus_rr.up_dph_err, bus_rr.up_dph_exokay, bus_rr.ahblm_hwdata};
            if (dph_q_rr.size() == 0) chk("rr_dph_unexpected", 64'(gd), 64'(0));
            else chk("rr_dph", 64'(gd), 64'(dph_q_rr.pop_front()));
        end
    end

    initial begin
        haddr_vec  = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        wdata_vec  = {32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        size_vec   = {3'd2, 3'd1, 3'd0};
        prot_vec   = {4'd10, 4'd9, 4'd8};
        hrdata     = 32'h5A5A_1234;
        rst_n_fp   = 1'b0;
        rst_n_rr   = 1'b0;
        req_fp     = '0;
        req_rr     = '0;
        write_v    = '0;
        excl_v     = '0;
        hready_fp  = 1'b1;
        hresp_fp   = 1'b0;
        hexokay_fp = 1'b0;
        hready_rr  = 1'b1;

        // Reset state
        repeat (2) step();
        #3;
        chk("rst_htrans", 64'(bus_fp.ahblm_htrans), 64'(0));
        chk("rst_dph", 64'({bus_fp.up_dph_ready, bus_fp.up_dph_err, bus_fp.up_dph_exokay}), 64'(0));
        chk("rst_boosted", 64'(bus_fp.up_boosted), 64'(0));
        chk("rst_hwdata", 64'(bus_fp.ahblm_hwdata), 64'(0));
        chk("rst_burst_lock", 64'({bus_fp.ahblm_hburst, bus_fp.ahblm_hmastlock}), 64'(0));
        chk("rdata_pass", 64'(bus_fp.up_rdata), 64'(32'h5A5A_1234));
        chk("rst_rr_idle", 64'({bus_rr.ahblm_htrans, bus_rr.up_dph_ready}), 64'(0));
        step();
        rst_n_fp = 1'b1;
        rst_n_rr = 1'b1;
        step();

        // Fixed priority with starvation boost: ports 0 and 2 request continuously
        for (int i = 0; i < 15; i++) aph_q_fp.push_back(mk_aph(0, 1'b0, 1'b0));
        aph_q_fp.push_back(mk_aph(2, 1'b0, 1'b0));
        repeat (2) aph_q_fp.push_back(mk_aph(0, 1'b0, 1'b0));
        for (int i = 0; i < 15; i++) dph_q_fp.push_back(mk_dph(0, 1'b1, 1'b0, 1'b0));
        dph_q_fp.push_back(mk_dph(2, 1'b1, 1'b0, 1'b0));
        repeat (2) dph_q_fp.push_back(mk_dph(0, 1'b1, 1'b0, 1'b0));
        req_fp = 3'b101;
        for (int i = 0; i < 18; i++) begin
            #3;
            if (i == 14) chk("boost_before", 64'(bus_fp.up_boosted), 64'(3'b000));
            if (i == 15) chk("boost_rise", 64'(bus_fp.up_boosted), 64'(3'b100));
            if (i == 16) chk("boost_clear", 64'(bus_fp.up_boosted), 64'(3'b000));
            step();
        end
        req_fp = 3'b000;
        #3;
        chk("idle_addr_fields", 64'({bus_fp.ahblm_htrans, bus_fp.ahblm_haddr, bus_fp.ahblm_hsize,
            bus_fp.ahblm_hprot, bus_fp.ahblm_hwrite, bus_fp.ahblm_hexcl}), 64'(0));
        step();

        // Address-phase hold across three wait states
        aph_q_fp.push_back(mk_aph(1, 1'b0, 1'b0));
        aph_q_fp.push_back(mk_aph(0, 1'b0, 1'b0));
        dph_q_fp.push_back(mk_dph(1, 1'b1, 1'b0, 1'b0));
        dph_q_fp.push_back(mk_dph(0, 1'b1, 1'b0, 1'b0));
        req_fp    = 3'b010;
        hready_fp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) req_fp = 3'b011;
            #3;
            chk("hold_aph", 64'({bus_fp.ahblm_htrans, bus_fp.ahblm_haddr, bus_fp.up_aph_ready}),
                64'({2'b10, 32'h0000_2000, 3'b000}));
            step();
        end
        hready_fp = 1'b1;
        step();
        req_fp = 3'b001;
        step();
        req_fp = 3'b000;
        step();

        // Two-cycle error response on a write, no hold during the error
        aph_q_fp.push_back(mk_aph(1, 1'b1, 1'b0));
        aph_q_fp.push_back(mk_aph(0, 1'b0, 1'b0));
        aph_q_fp.push_back(mk_aph(2, 1'b0, 1'b0));
        dph_q_fp.push_back(mk_dph(1, 1'b0, 1'b1, 1'b0));
        dph_q_fp.push_back(mk_dph(1, 1'b1, 1'b1, 1'b0));
        dph_q_fp.push_back(mk_dph(0, 1'b1, 1'b0, 1'b0));
        dph_q_fp.push_back(mk_dph(2, 1'b1, 1'b0, 1'b0));
        req_fp  = 3'b010;
        write_v = 3'b010;
        step();
        req_fp    = 3'b100;
        hready_fp = 1'b0;
        hresp_fp  = 1'b1;
        #3;
        chk("err_hwdata", 64'(bus_fp.ahblm_hwdata), 64'(32'hCAFE_0001));
        step();
        req_fp    = 3'b101;
        hready_fp = 1'b1;
        step();
        req_fp   = 3'b100;
        hresp_fp = 1'b0;
        step();
        req_fp  = 3'b000;
        write_v = 3'b000;
        step();

        // Exclusive store from port 2
        aph_q_fp.push_back(mk_aph(2, 1'b1, 1'b1));
        dph_q_fp.push_back(mk_dph(2, 1'b1, 1'b0, 1'b1));
        req_fp  = 3'b100;
        write_v = 3'b100;
        excl_v  = 3'b100;
        #3;
        chk("excl_aph", 64'(bus_fp.ahblm_hexcl), 64'(1));
        step();
        req_fp     = 3'b000;
        hexokay_fp = 1'b1;
        step();
        hexokay_fp = 1'b0;
        write_v    = 3'b000;
        excl_v     = 3'b000;
        step();

        // Round-robin rotation with all three ports requesting
        for (int k = 0; k < 4; k++) begin
            aph_q_rr.push_back(mk_aph(k % 3, 1'b0, 1'b0));
            dph_q_rr.push_back(mk_dph(k % 3, 1'b1, 1'b0, 1'b0));
        end
        req_rr = 3'b111;
        repeat (4) step();
        req_rr = 3'b000;
        repeat (2) step();

        // Reset in the middle of a stalled transfer
        req_rr    = 3'b010;
        hready_rr = 1'b0;
        step();
        #3;
        chk("stall_htrans", 64'({bus_rr.ahblm_htrans, bus_rr.ahblm_haddr}), 64'({2'b10, 32'h0000_2000}));
        rst_n_rr = 1'b0;
        #1;
        chk("midrst_idle", 64'({bus_rr.ahblm_htrans, bus_rr.ahblm_haddr, bus_rr.up_aph_ready,
            bus_rr.up_dph_ready, bus_rr.up_dph_err, bus_rr.up_boosted}), 64'(0));
        step();
        aph_q_rr.push_back(mk_aph(0, 1'b0, 1'b0));
        dph_q_rr.push_back(mk_dph(0, 1'b1, 1'b0, 1'b0));
        rst_n_rr  = 1'b1;
        req_rr    = 3'b111;
        hready_rr = 1'b1;
        step();
        req_rr = 3'b000;
        repeat (3) step();

        chk("fp_aph_leftover", 64'(aph_q_fp.size()), 64'(0));
        chk("fp_dph_leftover", 64'(dph_q_fp.size()), 64'(0));
        chk("rr_aph_leftover", 64'(aph_q_rr.size()), 64'(0));
        chk("rr_dph_leftover", 64'(dph_q_rr.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
